// File: rtl/sync_down_counter_pkg.sv
// sync_down_counter_pkg
// Shared FSM state type and the default counter width for the
// sync_down_counter block.
package sync_down_counter_pkg;

    localparam int WIDTH_DEFAULT = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/sync_down_counter_if.sv
// sync_down_counter_if
// Control/status bundle of the down counter.
//   load     : capture load_val as the new start value
//   load_val : start value for a countdown
//   en       : count enable
//   q        : current count
//   busy     : counter is running
//   done     : one-cycle terminal-count pulse
// master drives load/load_val/en, slave (the counter) drives q/busy/done.
interface sync_down_counter_if #(
    parameter int WIDTH = sync_down_counter_pkg::WIDTH_DEFAULT
);
    logic             load;
    logic [WIDTH-1:0] load_val;
    logic             en;
    logic [WIDTH-1:0] q;
    logic             busy;
    logic             done;

    modport master (output load, load_val, en, input q, busy, done);
    modport slave  (input load, load_val, en, output q, busy, done);
endinterface

// File: rtl/sync_down_counter_stage.sv
// down_cnt_stage
// One bit of the down counter.
//   clk, reset : shared clock, synchronous active-high reset
//   load_i     : overwrite the bit with d_i
//   d_i        : bit value to load
//   dec_i      : a decrement is being applied this cycle
//   borrow_i   : all lower bits are zero (bit 0 is tied high)
//   borrow_o   : this bit and all lower bits are zero
//   q_o        : bit value
module down_cnt_stage (
    input  logic clk,
    input  logic reset,
    input  logic load_i,
    input  logic d_i,
    input  logic dec_i,
    input  logic borrow_i,
    output logic borrow_o,
    output logic q_o
);
    logic bit_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            bit_q <= 1'b0;
        end else if (load_i) begin
            bit_q <= d_i;
        end else if (dec_i && borrow_i) begin
            bit_q <= ~bit_q;
        end
    end

    // The borrow chain doubles as a zero detector: the top borrow is high
    // exactly when the whole count is zero.
    assign borrow_o = borrow_i & ~bit_q;
    assign q_o      = bit_q;
endmodule

// File: rtl/sync_down_counter.sv
// sync_down_counter
// Loadable down counter with IDLE/RUN/DONE sequencing and a one-cycle
// terminal-count pulse.
//   clk   : clock, rising edge
//   reset : synchronous active-high reset
//   bus   : slave side of sync_down_counter_if (load, load_val, en in;
//           q, busy, done out)
// Build option: define SYNC_DOWN_COUNTER_AUTO_RELOAD_EN to restart from the
// last loaded value after DONE (periodic mode); otherwise DONE returns to
// IDLE with q held at 0.
//
// state | meaning
// IDLE  | stopped, q held, en ignored
// RUN   | counting down on enabled cycles
// DONE  | terminal count reached, done high for this cycle
module sync_down_counter
    import sync_down_counter_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEFAULT
) (
    input  logic                clk,
    input  logic                reset,
    sync_down_counter_if.slave  bus
);
    state_t           state_q, state_d;
    logic [WIDTH-1:0] reload_q;
    logic             busy_q, done_q;

    logic [WIDTH-1:0] cnt_q;
    logic [WIDTH:0]   borrow;
    logic             cnt_zero;
    logic             cnt_load;
    logic [WIDTH-1:0] cnt_val;
    logic             cnt_dec;

    assign borrow[0] = 1'b1;
    assign cnt_zero  = borrow[WIDTH];

    for (genvar i = 0; i < WIDTH; i++) begin : g_stage
        down_cnt_stage u_stage (
            .clk      (clk),
            .reset    (reset),
            .load_i   (cnt_load),
            .d_i      (cnt_val[i]),
            .dec_i    (cnt_dec),
            .borrow_i (borrow[i]),
            .borrow_o (borrow[i+1]),
            .q_o      (cnt_q[i])
        );
    end

    always_comb begin
        state_d  = state_q;
        cnt_load = 1'b0;
        cnt_val  = '0;
        cnt_dec  = 1'b0;
        if (bus.load) begin
            // Load wins over en and abandons any countdown in progress.
            cnt_load = 1'b1;
            cnt_val  = bus.load_val;
            state_d  = (bus.load_val != '0) ? RUN : DONE;
        end else begin
            case (state_q)
                RUN: begin
                    if (bus.en) begin
                        cnt_dec = ~cnt_zero;
                        if (cnt_q == WIDTH'(1) || cnt_zero) begin
                            state_d = DONE;
                        end
                    end
                end
                DONE: begin
`ifdef SYNC_DOWN_COUNTER_AUTO_RELOAD_EN
                    cnt_load = 1'b1;
                    cnt_val  = reload_q;
                    state_d  = (reload_q != '0) ? RUN : DONE;
`else
                    state_d  = IDLE;
`endif
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            reload_q <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            reload_q <= bus.load ? bus.load_val : reload_q;
            busy_q   <= (state_d == RUN);
            done_q   <= (state_d == DONE);
        end
    end

    assign bus.q    = cnt_q;
    assign bus.busy = busy_q;
    assign bus.done = done_q;
endmodule

// File: tb/tb_sync_down_counter.sv
module tb_sync_down_counter;
    localparam int W = 4;

    logic clk = 1'b0;
    logic reset;
    int   n_checks = 0;
    int   n_errors = 0;

    // Reference model: mode 0 = stopped, 1 = counting, 2 = terminal
    int m_q, m_mode, m_rel;

    always #5 clk = ~clk;

    sync_down_counter_if #(.WIDTH(W)) bus ();

    sync_down_counter #(.WIDTH(W)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    task automatic chk(input string tag, input int obs, input int exp);
        n_checks++;
        if (obs != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic model_step(input bit r, input bit ld, input int lv, input bit e);
        if (r) begin
            m_q = 0; m_rel = 0; m_mode = 0;
        end else if (ld) begin
            m_q = lv; m_rel = lv; m_mode = (lv != 0) ? 1 : 2;
        end else if (m_mode == 1) begin
            if (e) begin
                m_q = m_q - 1;
                if (m_q == 0) m_mode = 2;
            end
        end else if (m_mode == 2) begin
`ifdef SYNC_DOWN_COUNTER_AUTO_RELOAD_EN
            m_q = m_rel;
            m_mode = (m_rel != 0) ? 1 : 2;
`else
            m_mode = 0;
`endif
        end
    endtask

    // Called right after a falling edge: apply inputs, clock, compare.
    task automatic cycle(input string tag, input bit r, input bit ld, input int lv, input bit e);
        reset        = r;
        bus.load     = ld;
        bus.load_val = W'(lv);
        bus.en       = e;
        @(posedge clk);
        model_step(r, ld, lv, e);
        @(negedge clk);
        chk({tag, ".q"},    int'(bus.q),    m_q);
        chk({tag, ".busy"}, int'(bus.busy), (m_mode == 1) ? 1 : 0);
        chk({tag, ".done"}, int'(bus.done), (m_mode == 2) ? 1 : 0);
    endtask

    initial begin
        int exp_q[$];
        int dcount;
        m_q = 0; m_mode = 0; m_rel = 0;
        reset = 1'b1; bus.load = 1'b0; bus.load_val = '0; bus.en = 1'b0;
        @(negedge clk);

        cycle("rst", 1, 0, 0, 0);
        chk("rst.q0", int'(bus.q), 0);
        chk("rst.done0", int'(bus.done), 0);

        // load 5 then count down with en high
        exp_q = '{5, 4, 3, 2, 1, 0};
        cycle("s1", 0, 1, 5, 0);
        chk("s1.seq", int'(bus.q), exp_q[0]);
        for (int i = 1; i < 6; i++) begin
            cycle("s1", 0, 0, 0, 1);
            chk("s1.seq", int'(bus.q), exp_q[i]);
            chk("s1.donepos", int'(bus.done), (i == 5) ? 1 : 0);
        end
`ifndef SYNC_DOWN_COUNTER_AUTO_RELOAD_EN
        cycle("s1", 0, 0, 0, 1);
        chk("s1.busy_after", int'(bus.busy), 0);
        chk("s1.q_after", int'(bus.q), 0);
`endif
        cycle("rst", 1, 0, 0, 0);

        // load 3, en toggling
        exp_q = '{3, 2, 2, 1, 1, 0};
        dcount = 0;
        cycle("s2", 0, 1, 3, 0);
        chk("s2.seq", int'(bus.q), exp_q[0]);
        for (int i = 1; i < 6; i++) begin
            cycle("s2", 0, 0, 0, (i % 2) == 1);
            chk("s2.seq", int'(bus.q), exp_q[i]);
            dcount += int'(bus.done);
        end
        chk("s2.ndone", dcount, 1);
        cycle("rst", 1, 0, 0, 0);

        // reload mid-countdown
        exp_q = '{9, 8, 7, 6, 5, 4};
        dcount = 0;
        cycle("s3", 0, 1, 9, 0);
        for (int i = 1; i < 6; i++) begin
            cycle("s3", 0, 0, 0, 1);
            chk("s3.seq", int'(bus.q), exp_q[i]);
            dcount += int'(bus.done);
        end
        cycle("s3", 0, 1, 2, 1);
        chk("s3.reload", int'(bus.q), 2);
        cycle("s3", 0, 0, 0, 1);
        chk("s3.q1", int'(bus.q), 1);
        dcount += int'(bus.done);
        cycle("s3", 0, 0, 0, 1);
        chk("s3.q0", int'(bus.q), 0);
        dcount += int'(bus.done);
        chk("s3.ndone", dcount, 1);
        cycle("rst", 1, 0, 0, 0);

        // load zero
        cycle("s4", 0, 1, 0, 1);
        chk("s4.done", int'(bus.done), 1);
        chk("s4.q", int'(bus.q), 0);
        cycle("s4", 0, 0, 0, 1);
        chk("s4.q_hold", int'(bus.q), 0);
        cycle("rst", 1, 0, 0, 0);

        // reset beats load and en mid-countdown
        cycle("s5", 0, 1, 8, 0);
        cycle("s5", 0, 0, 0, 1);
        cycle("s5", 0, 0, 0, 1);
        chk("s5.q6", int'(bus.q), 6);
        cycle("s5", 1, 1, 5, 1);
        chk("s5.q", int'(bus.q), 0);
        chk("s5.busy", int'(bus.busy), 0);
        chk("s5.done", int'(bus.done), 0);

`ifdef SYNC_DOWN_COUNTER_AUTO_RELOAD_EN
        // periodic mode
        exp_q = '{2, 1, 0, 2, 1, 0};
        cycle("s6", 0, 1, 2, 1);
        chk("s6.seq", int'(bus.q), exp_q[0]);
        for (int i = 1; i < 6; i++) begin
            cycle("s6", 0, 0, 0, 1);
            chk("s6.seq", int'(bus.q), exp_q[i]);
            chk("s6.done", int'(bus.done), (i % 3 == 2) ? 1 : 0);
            chk("s6.busy", int'(bus.busy), (i % 3 == 2) ? 0 : 1);
        end
        cycle("rst", 1, 0, 0, 0);
`endif

        // random traffic against the model
        for (int i = 0; i < 400; i++) begin
            cycle("rnd",
                  $urandom_range(31) == 0,
                  $urandom_range(5) == 0,
                  int'($urandom_range((1 << W) - 1)),
                  $urandom_range(1) == 1);
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule

// File: doc/sync_down_counter.md
SYNC_DOWN_COUNTER -- requirements
Module: sync_down_counter

Interface
REQ-001 The block SHALL have parameter WIDTH, default 4, meaning the counter width in bits, legal range 2..16.
REQ-002 The block SHALL have port clk, input, 1 bit, the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port reset, input, 1 bit, synchronous active-high reset, sampled on the rising edge of clk.
REQ-004 The block SHALL have port load, input, 1 bit, which requests that load_val be captured as the start value.
REQ-005 The block SHALL have port load_val, input, WIDTH bits, the start value for a countdown.
REQ-006 The block SHALL have port en, input, 1 bit, the count enable; one decrement per enabled cycle while running.
REQ-007 The block SHALL have port q, output, WIDTH bits, the registered current count.
REQ-008 The block SHALL have port busy, output, 1 bit, high while the state is RUN.
REQ-009 The block SHALL have port done, output, 1 bit, a registered pulse that is high for exactly one cycle at terminal count.

Function
REQ-010 The block SHALL implement an FSM with states IDLE, RUN and DONE; all outputs are registered or decoded from state only.
REQ-011 Load with nonzero value, from any state: next cycle q=load_val, reload register=load_val, state RUN.
REQ-012 Load with load_val=0, from any state: next cycle q=0, reload register=0, state DONE, so that done pulses once.
REQ-013 Load SHALL take priority over en in the same cycle, and an in-progress countdown is abandoned.
REQ-014 In RUN with en=1 and q>1, q SHALL decrement by 1; with en=0, q holds.
REQ-015 In RUN with en=1 and q=1, next cycle q=0 and state DONE.
REQ-016 In DONE, done=1 for that single cycle only.
REQ-017 In IDLE, q SHALL hold and en SHALL be ignored; q never wraps from 0 to all-ones.
REQ-018 Latency from load asserted to first decrement SHALL be 2 cycles: a capture cycle, then the first enabled RUN cycle.
REQ-019 A countdown of N with en held high SHALL assert done exactly N cycles after the load-capture cycle.

Reset
REQ-020 With reset=1 at a clock edge, next state SHALL be IDLE, q=0, reload register=0, busy=0, done=0.
REQ-021 Reset SHALL override load and en in the same cycle, including mid-countdown and during DONE.

Configuration
REQ-022 The block SHALL use macro SYNC_DOWN_COUNTER_AUTO_RELOAD_EN to select behaviour on leaving DONE.
REQ-023 With the macro defined, DONE SHALL be followed by q=reload value and state RUN (periodic mode); a reload value of 0 gives DONE every cycle.
REQ-024 With the macro undefined, DONE SHALL be followed by state IDLE with q=0 held, and the reload register is still written but unused.

Structure
REQ-025 Package sync_down_counter_pkg SHALL hold the FSM state typedef (2-bit enum IDLE/RUN/DONE) and the WIDTH default constant.
REQ-026 The count register SHALL be built from WIDTH instances of the sub-module down_cnt_stage: one bit, synchronous reset, load, and borrow-in/borrow-out chaining with a single shared clk.

Verification
REQ-027 The bench SHALL cover: reset, then load=1 with load_val=5, then en high -> q sequence 5,4,3,2,1,0; done high in exactly the q=0 cycle; busy low afterwards.
REQ-028 The bench SHALL cover: load_val=3 with en toggling 1,0,1,0,1 -> q 3,2,2,1,1,0; done once.
REQ-029 The bench SHALL cover: load_val=9, and at q=4 assert load with load_val=2 -> q=2 next cycle, then 1,0; a single done.
REQ-030 The bench SHALL cover: load_val=0 -> done pulses the next cycle, and q stays 0.
REQ-031 The bench SHALL cover: reset asserted at q=6 while en=1 and load=1 -> next cycle q=0, IDLE, done=0.
REQ-032 The bench SHALL cover: macro defined, load_val=2, en held high -> q 2,1,0,2,1,0; done every 3rd cycle; busy low only in the DONE cycles.
